// File: rtl/stage_1_control.sv
// rtl/stage_1_control.sv - multicycle control FSM for the Stage_1 memory-to-memory datapath
module stage_1_control #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        isTrue,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    output logic        ld_en,
    output logic [2:0]  ld_sel,
    output logic        writepc,
    output logic        WEpc,
    output logic [1:0]  ALUsrca,
    output logic [1:0]  ALUsrcb,
    output logic [3:0]  ALUOp,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [3:0] {
        S_FETCH, S_PCINC, S_OPF, S_OPINC, S_RDA, S_RDB,
        S_WRITE, S_CMP, S_BRANCH, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_BEQ  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  timer_q, timer_d;
    logic        take_q, take_d;
    logic        fault_q, fault_d;

    logic        req_r, we_r, wepc_r, writepc_r;
    logic [1:0]  sel_r, srca_r, srcb_r;
    logic [2:0]  ld_sel_r;
    logic [3:0]  aluop_r;

    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[11:0];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= 4'h0;
            cnt_q   <= 2'd0;
            timer_q <= 8'd0;
            take_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            take_q  <= take_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        take_d  = take_q;
        fault_d = fault_q;
        timer_d = (req_r && !mem_ack) ? 8'(timer_q + 8'd1) : 8'd0;
        case (state_q)
            S_FETCH: if (mem_ack) begin
                op_d    = mem_rdata[15:12];
                state_d = S_PCINC;
            end
            S_PCINC: begin
                if (op_q == OP_HALT) begin
                    state_d = S_HALT;
                end else if (op_q > OP_JMP) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d   = (op_q == OP_JMP) ? 2'd1 : 2'd3;
                    state_d = S_OPF;
                end
            end
            S_OPF:   if (mem_ack) state_d = S_OPINC;
            S_OPINC: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q > 2'd1)        state_d = S_OPF;
                else if (op_q == OP_JMP) state_d = S_BRANCH;
                else                     state_d = S_RDA;
            end
            S_RDA:   if (mem_ack) state_d = S_RDB;
            S_RDB:   if (mem_ack) state_d = (op_q == OP_BEQ) ? S_CMP : S_WRITE;
            S_WRITE: if (mem_ack) state_d = S_FETCH;
            S_CMP: begin
                take_d  = isTrue;
                state_d = S_BRANCH;
            end
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // A stuck bus overrides whatever access was pending.
        if (req_r && !mem_ack && timer_d == 8'(WAIT_LIMIT)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
        end
    end

    always_comb begin
        req_r     = 1'b0;
        we_r      = 1'b0;
        sel_r     = 2'd0;
        ld_sel_r  = 3'd0;
        wepc_r    = 1'b0;
        writepc_r = 1'b0;
        srca_r    = 2'd1;
        srcb_r    = 2'd1;
        aluop_r   = OP_ADD;
        case (state_q)
            S_FETCH: req_r = 1'b1;
            S_PCINC: wepc_r = 1'b1;
            S_OPF: begin
                req_r    = 1'b1;
                ld_sel_r = 3'(3'd4 - {1'b0, cnt_q});
            end
            S_OPINC: wepc_r = 1'b1;
            S_RDA: begin
                req_r    = 1'b1;
                sel_r    = 2'd1;
                ld_sel_r = 3'd4;
            end
            S_RDB: begin
                req_r    = 1'b1;
                sel_r    = 2'd2;
                ld_sel_r = 3'd5;
            end
            S_WRITE: begin
                req_r   = 1'b1;
                we_r    = 1'b1;
                sel_r   = 2'd3;
                srca_r  = 2'd0;
                srcb_r  = 2'd0;
                aluop_r = op_q;
            end
            S_CMP: begin
                srca_r  = 2'd0;
                srcb_r  = 2'd0;
                aluop_r = OP_SUB;
            end
            S_BRANCH: begin
                writepc_r = 1'b1;
                wepc_r    = (op_q == OP_JMP) ? 1'b1 : take_q;
            end
            default: ;
        endcase
        // Outputs are forced low while reset is held, independent of the clock.
        mem_req      = reset & req_r;
        mem_we       = reset & we_r;
        mem_addr_sel = reset ? sel_r : 2'd0;
        ld_en        = reset & req_r & mem_ack & ~we_r;
        ld_sel       = reset ? ld_sel_r : 3'd0;
        writepc      = reset & writepc_r;
        WEpc         = reset & wepc_r;
        ALUsrca      = reset ? srca_r : 2'd0;
        ALUsrcb      = reset ? srcb_r : 2'd0;
        ALUOp        = reset ? aluop_r : 4'd0;
        halted       = reset & (state_q == S_HALT);
        fault        = reset & fault_q;
    end

endmodule

// File: tb/tb_stage_1_control.sv
// tb/tb_stage_1_control.sv - scoreboard bench for stage_1_control with a Stage_1 datapath and memory around it
module tb_stage_1_control;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_rdata;
    logic        mem_ack = 1'b0;
    logic        isTrue;
    logic        mem_req, mem_we, ld_en, writepc, WEpc, halted, fault;
    logic [1:0]  mem_addr_sel, ALUsrca, ALUsrcb;
    logic [2:0]  ld_sel;
    logic [3:0]  ALUOp;

    always #5 CLK = ~CLK;

    stage_1_control #(.WAIT_LIMIT(64)) dut (
        .CLK(CLK), .reset(reset), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .isTrue(isTrue),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ld_en(ld_en),
        .ld_sel(ld_sel), .writepc(writepc), .WEpc(WEpc), .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb),
        .ALUOp(ALUOp), .halted(halted), .fault(fault)
    );

    // Stage_1 datapath and a 256-word memory
    logic [15:0] mem [256];
    logic [15:0] init_mem [256];
    logic [15:0] pc, aaddr, baddr, dreg, adata, bdata;
    logic [15:0] addr, srca, srcb, alu;
    int cyc = 0;

    always_comb begin
        addr = pc;
        case (mem_addr_sel)
            2'd1:    addr = aaddr;
            2'd2:    addr = baddr;
            2'd3:    addr = dreg;
            default: addr = pc;
        endcase
        srca = (ALUsrca == 2'd1) ? pc : adata;
        srcb = (ALUsrcb == 2'd1) ? 16'd1 : bdata;
        alu  = (ALUOp == 4'd1) ? 16'(srca - srcb) : 16'(srca + srcb);
    end
    assign mem_rdata = mem[addr[7:0]];
    assign isTrue    = (alu == 16'd0);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            pc <= 16'd0; aaddr <= 16'd0; baddr <= 16'd0;
            dreg <= 16'd0; adata <= 16'd0; bdata <= 16'd0;
        end else begin
            if (ld_en) begin
                case (ld_sel)
                    3'd1: aaddr <= mem_rdata;
                    3'd2: baddr <= mem_rdata;
                    3'd3: dreg  <= mem_rdata;
                    3'd4: adata <= mem_rdata;
                    3'd5: bdata <= mem_rdata;
                    default: ;
                endcase
            end
            if (WEpc) pc <= writepc ? dreg : alu;
            if (mem_req && mem_ack && mem_we) mem[addr[7:0]] <= alu;
        end
    end

    // Memory responder: each access waits cur_dly cycles before ack
    int wcnt = 0, cur_dly = 0, dly_lo = 0, dly_hi = 0;
    always @(negedge CLK) begin
        if (!reset) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            cur_dly = int'($urandom_range(dly_hi, dly_lo));
        end else begin
            if (mem_ack) begin
                wcnt    = 0;
                cur_dly = int'($urandom_range(dly_hi, dly_lo));
            end
            if (mem_req && wcnt >= cur_dly) mem_ack = 1'b1;
            else begin
                mem_ack = 1'b0;
                if (mem_req) wcnt++;
            end
        end
    end

    int n_pass = 0, n_total = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard queues and monitor
    logic [15:0] q_fetch [$];
    int          q_gap [$];
    logic [31:0] q_wr [$];
    bit          chk_en = 1'b0;
    int          wepc_cnt = 0, last_fetch = 0;
    logic [15:0] e_pc;
    int          e_gap;
    logic [31:0] e_wr;

    always begin
        @(negedge CLK);
        #1;
        if (!reset) wepc_cnt = 0;
        else if (chk_en) begin
            if (WEpc) wepc_cnt++;
            if (mem_req && mem_ack && !mem_we && ld_sel == 3'd0) begin
                chk("fetch_expected", 32'(q_fetch.size() > 0), 32'd1);
                if (q_fetch.size() > 0) begin
                    e_pc  = q_fetch.pop_front();
                    e_gap = q_gap.pop_front();
                    chk("fetch_addr", 32'(addr), 32'(e_pc));
                    if (e_gap >= 0) chk("instr_cycles", 32'(cyc - last_fetch), 32'(e_gap));
                end
                last_fetch = cyc;
            end
            if (mem_req && mem_ack && mem_we) begin
                chk("write_expected", 32'(q_wr.size() > 0), 32'd1);
                if (q_wr.size() > 0) begin
                    e_wr = q_wr.pop_front();
                    chk("write_addr", 32'(addr), 32'(e_wr[31:16]));
                    chk("write_data", 32'(alu), 32'(e_wr[15:0]));
                end
            end
        end
    end

    // Instruction-level reference model
    logic [15:0] mm [256];
    logic [15:0] m_pc;
    int          m_wepc;
    bit          m_fault;

    function automatic logic [15:0] next_word();
        logic [15:0] w;
        w = mm[m_pc[7:0]];
        m_pc = m_pc + 16'd1;
        m_wepc++;
        return w;
    endfunction

    task automatic model_run(input int fdly);
        logic [15:0] w, a, b, d, va, vb, res;
        int base, acc, pend_gap;
        for (int i = 0; i < 256; i++) mm[i] = init_mem[i];
        m_pc = 16'd0; m_wepc = 0; m_fault = 1'b0; pend_gap = -1;
        for (int n = 0; n < 200; n++) begin
            q_fetch.push_back(m_pc);
            q_gap.push_back(pend_gap);
            w = next_word();
            if (w[15:12] <= 4'h2) begin
                a = next_word(); b = next_word(); d = next_word();
                va = mm[a[7:0]]; vb = mm[b[7:0]];
                if (w[15:12] == 4'h2) begin
                    if (va == vb) begin m_pc = d; m_wepc++; end
                    base = 12; acc = 6;
                end else begin
                    res = (w[15:12] == 4'h0) ? 16'(va + vb) : 16'(va - vb);
                    mm[d[7:0]] = res;
                    q_wr.push_back({d, res});
                    base = 11; acc = 7;
                end
            end else if (w[15:12] == 4'h3) begin
                d = next_word();
                m_pc = d; m_wepc++;
                base = 5; acc = 2;
            end else begin
                m_fault = (w[15:12] != 4'hF);
                break;
            end
            pend_gap = (fdly >= 0) ? base + acc * fdly : -1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) init_mem[i] = 16'd0;
    endtask

    task automatic run_prog(input string nm, input int lo, input int hi);
        bit done;
        int bad;
        reset = 1'b0; chk_en = 1'b0; dly_lo = lo; dly_hi = hi;
        q_fetch.delete(); q_gap.delete(); q_wr.delete();
        model_run((lo == hi) ? lo : -1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1; chk_en = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge CLK); #2;
            if (halted) done = 1'b1;
        end
        chk({nm, "_halted"}, 32'(done), 32'd1);
        chk({nm, "_fault"}, 32'(fault), 32'(m_fault));
        chk({nm, "_pc"}, 32'(pc), 32'(m_pc));
        chk({nm, "_wepc_pulses"}, 32'(wepc_cnt), 32'(m_wepc));
        chk({nm, "_fetch_left"}, 32'(q_fetch.size()), 32'd0);
        chk({nm, "_write_left"}, 32'(q_wr.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
        chk({nm, "_mem_words_wrong"}, 32'(bad), 32'd0);
        chk_en = 1'b0;
    endtask

    task automatic gen_random();
        int k, j;
        logic [3:0] ops [8];
        logic [15:0] at [8];
        logic [15:0] p, a;
        k = int'($urandom_range(6, 2));
        for (int i = 0; i < k; i++) ops[i] = 4'($urandom_range(3, 0));
        ops[k] = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(14, 4)) : 4'hF;
        p = 16'd0;
        for (int i = 0; i <= k; i++) begin
            at[i] = p;
            p = p + ((ops[i] <= 4'h2) ? 16'd4 : (ops[i] == 4'h3) ? 16'd2 : 16'd1);
        end
        for (int i = 0; i < 256; i++) init_mem[i] = (i >= 192) ? 16'($urandom) : 16'd0;
        for (int i = 0; i <= k; i++) begin
            init_mem[at[i][7:0]] = {ops[i], 12'($urandom)};
            j = int'($urandom_range(k, i + 1));
            if (ops[i] <= 4'h2) begin
                a = 16'(192 + $urandom_range(63, 0));
                init_mem[at[i][7:0] + 8'd1] = a;
                init_mem[at[i][7:0] + 8'd2] = ($urandom_range(1, 0) == 1) ? a : 16'(192 + $urandom_range(63, 0));
                init_mem[at[i][7:0] + 8'd3] = (ops[i] == 4'h2) ? at[j] : 16'(192 + $urandom_range(63, 0));
            end else if (ops[i] == 4'h3) begin
                init_mem[at[i][7:0] + 8'd1] = at[j];
            end
        end
    endtask

    initial begin
        // Reset asserted mid-WRITE while the request is outstanding
        clear_mem();
        init_mem[0] = 16'h0000; init_mem[1] = 16'd10; init_mem[2] = 16'd11; init_mem[3] = 16'd12;
        init_mem[4] = 16'hF000; init_mem[10] = 16'd5; init_mem[11] = 16'd7;
        reset = 1'b0; dly_lo = 3; dly_hi = 3;
        repeat (2) @(posedge CLK);
        @(negedge CLK); reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK); #1;
            if (mem_we) break;
        end
        chk("rst_reached_write", 32'(mem_we & mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_outputs_zero", 32'({mem_req, mem_we, mem_addr_sel, ld_en, ld_sel, writepc, WEpc,
                                     ALUsrca, ALUsrcb, ALUOp, halted, fault}), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); reset = 1'b1;
        #1;
        chk("rst_release_fetch", 32'({mem_req, mem_we, mem_addr_sel, ld_sel}), 32'b1_0_00_000);

        run_prog("add", 0, 0);
        chk("add_m12", 32'(mem[12]), 32'd12);

        init_mem[0] = 16'h1000;
        run_prog("sub_wait3", 3, 3);
        chk("sub_m12", 32'(mem[12]), 32'h0000FFFE);

        clear_mem();
        init_mem[0] = 16'h2000; init_mem[1] = 16'd10; init_mem[2] = 16'd11; init_mem[3] = 16'h0020;
        init_mem[4] = 16'hF000; init_mem[16'h20] = 16'hF000; init_mem[10] = 16'd9; init_mem[11] = 16'd9;
        run_prog("beq_taken", 0, 0);
        chk("beq_taken_pc", 32'(pc), 32'h21);
        init_mem[11] = 16'd8;
        run_prog("beq_not", 0, 0);
        chk("beq_not_pc", 32'(pc), 32'h5);

        clear_mem();
        init_mem[0] = 16'h3000; init_mem[1] = 16'h0040; init_mem[16'h40] = 16'hF000;
        run_prog("jmp", 0, 0);
        chk("jmp_pc", 32'(pc), 32'h41);

        clear_mem();
        init_mem[0] = 16'h7000;
        run_prog("illegal", 0, 0);
        chk("illegal_fault", 32'(fault), 32'd1);

        // Bus timeout: ack withheld forever
        reset = 1'b0; chk_en = 1'b0; dly_lo = 1000; dly_hi = 1000;
        repeat (2) @(posedge CLK);
        @(negedge CLK); reset = 1'b1;
        repeat (63) @(posedge CLK);
        @(negedge CLK); #1;
        chk("timeout_not_yet", 32'({halted, fault}), 32'd0);
        @(posedge CLK);
        @(negedge CLK); #1;
        chk("timeout_halt_fault", 32'({halted, fault, mem_req}), 32'b110);

        for (int r = 0; r < 10; r++) begin
            gen_random();
            if (r % 3 == 0)      run_prog("rnd_zero", 0, 0);
            else if (r % 3 == 1) run_prog("rnd_var", 0, 3);
            else                 run_prog("rnd_fixed2", 2, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
